// File: rtl/pe_sequencer_if.sv
// Signal bundle between pe_sequencer, the host/dispatcher and its Processing Element.
// The slave modport is the sequencer's view; the master modport is the host + PE side.
interface pe_sequencer_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [1:0]        dimen;
    logic              busy;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ack;
    logic              err;
    logic [DATA_W-1:0] pe_datain;
    logic              pe_rst_add;
    logic              pe_rst_pc;
    logic              pe_rst_acc;
    logic              pe_mat_mux;
    logic              pe_write_mat;
    logic              pe_mac_ctrl;
    logic              pe_out_ready;
    logic [1:0]        pe_dimen;
    logic              pe_mac_done;
    logic [DATA_W-1:0] pe_dataout;

    modport slave (
        input  start, dimen, in_valid, in_data, out_ack, pe_mac_done, pe_dataout,
        output busy, in_ready, out_valid, out_data, err, pe_datain,
               pe_rst_add, pe_rst_pc, pe_rst_acc, pe_mat_mux, pe_write_mat,
               pe_mac_ctrl, pe_out_ready, pe_dimen
    );

    modport master (
        output start, dimen, in_valid, in_data, out_ack, pe_mac_done, pe_dataout,
        input  busy, in_ready, out_valid, out_data, err, pe_datain,
               pe_rst_add, pe_rst_pc, pe_rst_acc, pe_mat_mux, pe_write_mat,
               pe_mac_ctrl, pe_out_ready, pe_dimen
    );
endinterface

// File: rtl/pe_sequencer.sv
// pe_sequencer: runs one dot-product job on a single PE. It loads vector A, then
// vector B, drives the MAC phase until the PE signals its last element, and holds
// the 32-bit accumulator for the host until it is acknowledged.
module pe_sequencer #(
    parameter int N      = 16,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    pe_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD_A,
        S_LOAD_B,
        S_MAC,
        S_OUT
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]  mac_cnt_q, mac_cnt_d;
    logic [1:0]        dimen_q, dimen_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              in_ready_q, in_ready_d;
    logic              mat_mux_q, mat_mux_d;
    logic              mac_ctrl_q, mac_ctrl_d;
    logic              out_valid_q, out_valid_d;
    logic              strobe_q, strobe_d;
    logic              last_word_q, last_word_d;
    logic [CNT_W-1:0]  last_idx;
    logic              mac_at_last;
    logic [DATA_W-1:0] out_data_mux;

    // Index of the final element for a length code: L-1 with L = 2^(code+1).
    function automatic logic [CNT_W-1:0] last_index(input logic [1:0] code);
        logic [5:0] len;
        len = 6'd2 << code;
        return CNT_W'(len - 6'd1);
    endfunction

    // Next-state, counter and registered-output decode; outputs are derived from the
    // next state so that they line up with the state they describe once registered.
    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        mac_cnt_d   = mac_cnt_q;
        dimen_d     = dimen_q;
        err_d       = err_q;
        last_idx    = last_index(dimen_q);
        mac_at_last = (mac_cnt_q == last_idx);

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    dimen_d = bus.dimen;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                word_cnt_d = '0;
                mac_cnt_d  = '0;
                state_d    = S_LOAD_A;
            end
            S_LOAD_A, S_LOAD_B: begin
                if (bus.in_valid) begin
                    if (word_cnt_q == last_idx) begin
                        word_cnt_d = '0;
                        state_d    = (state_q == S_LOAD_A) ? S_LOAD_B : S_MAC;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
            end
            S_MAC: begin
                mac_cnt_d = mac_cnt_q + 1'b1;
                if (bus.pe_mac_done || mac_at_last) begin
                    mac_cnt_d = '0;
                    state_d   = S_OUT;
                    if (bus.pe_mac_done != mac_at_last) begin
                        err_d = 1'b1;
                    end
                end
            end
            S_OUT: begin
                if (bus.out_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d      = (state_d != S_IDLE);
        in_ready_d  = (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
        mat_mux_d   = (state_d == S_LOAD_A);
        mac_ctrl_d  = (state_d == S_MAC);
        out_valid_d = (state_d == S_OUT);
        strobe_d    = (state_d == S_IDLE) || (state_d == S_CLEAR);
        last_word_d = in_ready_d && (word_cnt_d == last_index(dimen_d));
    end

    // State, counters, sticky error and registered outputs; reset aborts any job.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            word_cnt_q  <= '0;
            mac_cnt_q   <= '0;
            dimen_q     <= 2'd0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            mat_mux_q   <= 1'b0;
            mac_ctrl_q  <= 1'b0;
            out_valid_q <= 1'b0;
            strobe_q    <= 1'b1;
            last_word_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            mac_cnt_q   <= mac_cnt_d;
            dimen_q     <= dimen_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
            mat_mux_q   <= mat_mux_d;
            mac_ctrl_q  <= mac_ctrl_d;
            out_valid_q <= out_valid_d;
            strobe_q    <= strobe_d;
            last_word_q <= last_word_d;
        end
    end

    // The result is only passed through while it is being offered to the host.
    always_comb begin
        out_data_mux = out_valid_q ? bus.pe_dataout : '0;
    end

    // The address reset on the last load word is tied to that word actually being
    // accepted, so a stall on the final element does not move the PE address early.
    assign bus.busy         = busy_q;
    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_mux;
    assign bus.err          = err_q;
    assign bus.pe_datain    = bus.in_data;
    assign bus.pe_rst_add   = strobe_q | (last_word_q & bus.in_valid);
    assign bus.pe_rst_pc    = strobe_q;
    assign bus.pe_rst_acc   = strobe_q;
    assign bus.pe_mat_mux   = mat_mux_q;
    assign bus.pe_write_mat = in_ready_q & bus.in_valid;
    assign bus.pe_mac_ctrl  = mac_ctrl_q;
    assign bus.pe_out_ready = out_valid_q;
    assign bus.pe_dimen     = dimen_q;
endmodule

// File: tb/tb_pe_sequencer.sv
// Testbench for pe_sequencer: a behavioural PE, a result scoreboard fed at job
// launch and drained when OUT_VALID rises, and directed jobs covering stalls,
// held results, mid-job reset and an early MAC-done fault in the PE.
module tb_pe_sequencer;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   pe_sequencer_if #(.DATA_W(32)) bus ();

   pe_sequencer #(.N(16), .DATA_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int checks = 0;
   int errors = 0;
   logic [31:0] expQ[$];
   logic [31:0] aVec[16];
   logic [31:0] bVec[16];
   int earlyDone = 0;

   // Compare one observed value with its expected value and report a mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural PE: writes at the current address, MACs at the program counter.
   logic [31:0] matA[16];
   logic [31:0] matB[16];
   logic [3:0]  peAddr;
   logic [3:0]  pePc;
   logic [31:0] peAcc;

   always @(posedge clk) begin
      if (bus.pe_write_mat) begin
         if (bus.pe_mat_mux) matA[peAddr] <= bus.pe_datain;
         else                matB[peAddr] <= bus.pe_datain;
      end
      if (bus.pe_rst_add)        peAddr <= 4'd0;
      else if (bus.pe_write_mat) peAddr <= peAddr + 4'd1;
      if (bus.pe_rst_pc)         pePc <= 4'd0;
      else if (bus.pe_mac_ctrl)  pePc <= pePc + 4'd1;
      if (bus.pe_rst_acc)        peAcc <= 32'd0;
      else if (bus.pe_mac_ctrl)  peAcc <= peAcc + matA[pePc] * matB[pePc];
   end

   assign bus.pe_dataout  = bus.pe_out_ready ? peAcc : 32'd0;
   assign bus.pe_mac_done = bus.pe_mac_ctrl &&
                            (int'(pePc) == (2 << bus.pe_dimen) - 1 - earlyDone);

   // Monitor: pulse counters and scoreboard drain on each rising OUT_VALID.
   logic prevOutValid = 1'b0;
   int writePulses = 0;
   int macCycles   = 0;
   int strayWrites = 0;

   always @(negedge clk) begin
      prevOutValid <= bus.out_valid;
      if (bus.pe_write_mat) writePulses <= writePulses + 1;
      if (bus.pe_mac_ctrl)  macCycles   <= macCycles + 1;
      if (bus.pe_write_mat && !bus.in_valid) strayWrites <= strayWrites + 1;
      if (bus.out_valid && !prevOutValid) begin
         checkOutput("sb_pending", 32'(expQ.size() != 0), 32'd1);
         if (expQ.size() != 0) checkOutput("result", bus.out_data, expQ.pop_front());
      end
   end

   // Offer `count` words (A then B) from posedge+1; optionally stall every other load cycle.
   task automatic feedWords(input int len, input int count, input bit stall, inout int n);
      int idx;
      int guard;
      bit phase;
      bit taken;
      idx = 0;
      guard = 0;
      phase = 1'b0;
      while (idx < count && guard < 200) begin
         if (bus.in_ready) begin
            bus.in_valid = stall ? phase : 1'b1;
            phase = ~phase;
         end else begin
            bus.in_valid = 1'b1;
         end
         bus.in_data = (idx < len) ? aVec[idx] : bVec[(idx >= len) ? idx - len : 0];
         @(negedge clk);
         taken = bus.in_ready && bus.in_valid;
         @(posedge clk);
         #1;
         n++;
         guard++;
         if (taken) idx++;
      end
      bus.in_valid = 1'b0;
      if (idx < count) checkOutput("load_timeout", idx, count);
   endtask

   // Run one full job: push the expected result, load, wait for OUT, hold, ack.
   task automatic applyStimulus(input int code, input bit stall, input int ackWait,
                                input bit pokeStart, input int expLat, input bit expErr);
      int len;
      int nMac;
      int n;
      int w0;
      int m0;
      int s0;
      bit seen;
      logic [31:0] sum;
      len = 2 << code;
      nMac = len - earlyDone;
      sum = 32'd0;
      for (int i = 0; i < nMac; i++) sum = sum + aVec[i] * bVec[i];
      expQ.push_back(sum);

      @(posedge clk);
      #1;
      w0 = writePulses;
      m0 = macCycles;
      s0 = strayWrites;
      bus.start = 1'b1;
      bus.dimen = 2'(code);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.dimen = 2'(code ^ 3);
      n = 1;
      feedWords(len, 2 * len, stall, n);

      seen = 1'b0;
      for (int g = 0; g < 200; g++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("out_seen", 32'(seen), 32'd1);
      checkOutput("latency", n, expLat);

      for (int i = 0; i < ackWait; i++) begin
         @(posedge clk);
         #1;
         bus.start = pokeStart && (i == 1);
         @(negedge clk);
         checkOutput("hold_valid", 32'(bus.out_valid), 32'd1);
         checkOutput("hold_data", bus.out_data, sum);
      end
      bus.start = 1'b0;
      bus.out_ack = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ack = 1'b0;
      @(negedge clk);
      checkOutput("idle_after_ack", 32'(bus.busy), 32'd0);
      checkOutput("out_valid_drop", 32'(bus.out_valid), 32'd0);
      checkOutput("out_data_zero", bus.out_data, 32'd0);
      checkOutput("err", 32'(bus.err), 32'(expErr));
      #1;
      checkOutput("write_pulses", writePulses - w0, 2 * len);
      checkOutput("mac_cycles", macCycles - m0, nMac);
      checkOutput("stray_writes", strayWrites - s0, 0);
   endtask

   // Start a job, reset it once the first B word is in, and check the reset state.
   task automatic abortInLoadB(input int code);
      int len;
      int n;
      len = 2 << code;
      @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.dimen = 2'(code);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      n = 1;
      feedWords(len, len + 1, 1'b0, n);
      @(negedge clk);
      checkOutput("in_load_b", {30'd0, bus.in_ready, bus.pe_mat_mux}, 32'd2);
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      checkOutput("abort_busy", 32'(bus.busy), 32'd0);
      checkOutput("abort_ctrl", {29'd0, bus.in_ready, bus.pe_mac_ctrl, bus.out_valid}, 32'd0);
      checkOutput("abort_strobes", {29'd0, bus.pe_rst_add, bus.pe_rst_pc, bus.pe_rst_acc}, 32'd7);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      bus.start = 1'b0;
      bus.dimen = 2'd0;
      bus.in_valid = 1'b1;
      bus.in_data = 32'hdead_beef;
      bus.out_ack = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_busy", 32'(bus.busy), 32'd0);
      checkOutput("rst_handshake", {29'd0, bus.in_ready, bus.out_valid, bus.err}, 32'd0);
      checkOutput("rst_out_data", bus.out_data, 32'd0);
      checkOutput("rst_pe_ctrl", {26'd0, bus.pe_mac_ctrl, bus.pe_write_mat, bus.pe_out_ready,
                                  bus.pe_mat_mux, bus.pe_dimen}, 32'd0);
      checkOutput("rst_strobes", {29'd0, bus.pe_rst_add, bus.pe_rst_pc, bus.pe_rst_acc}, 32'd7);
      checkOutput("datain_pass", bus.pe_datain, 32'hdead_beef);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.in_valid = 1'b0;

      $display("[TB] job L=2, no stalls");
      aVec[0] = 32'd3;  aVec[1] = 32'd5;
      bVec[0] = 32'd7;  bVec[1] = 32'd11;
      applyStimulus(0, 1'b0, 0, 1'b0, 8, 1'b0);

      $display("[TB] job L=16, A=1..16, B=1");
      for (int i = 0; i < 16; i++) begin
         aVec[i] = 32'(i + 1);
         bVec[i] = 32'd1;
      end
      applyStimulus(3, 1'b0, 0, 1'b0, 50, 1'b0);

      $display("[TB] job L=4 with alternating stalls");
      for (int i = 0; i < 4; i++) begin
         aVec[i] = 32'd2;
         bVec[i] = 32'd2;
      end
      applyStimulus(1, 1'b1, 0, 1'b0, 22, 1'b0);

      $display("[TB] job L=2 with held ack and START poke during OUT");
      aVec[0] = 32'd100;        aVec[1] = 32'hffff_ffff;
      bVec[0] = 32'd2;          bVec[1] = 32'd3;
      applyStimulus(0, 1'b0, 5, 1'b1, 8, 1'b0);

      $display("[TB] follow-up job L=8 with random data");
      for (int i = 0; i < 8; i++) begin
         aVec[i] = $urandom;
         bVec[i] = $urandom;
      end
      applyStimulus(2, 1'b0, 0, 1'b0, 26, 1'b0);

      $display("[TB] reset during LOAD_B, then fresh job");
      aVec[0] = 32'h0001_0000;  aVec[1] = 32'd1;
      bVec[0] = 32'd9;          bVec[1] = 32'd9;
      abortInLoadB(0);
      bVec[0] = 32'h0001_0000;  bVec[1] = 32'd4;
      applyStimulus(0, 1'b0, 0, 1'b0, 8, 1'b0);

      $display("[TB] PE raises MAC done one element early, L=4");
      earlyDone = 1;
      aVec[0] = 32'd1; aVec[1] = 32'd2; aVec[2] = 32'd3; aVec[3] = 32'd4;
      bVec[0] = 32'd5; bVec[1] = 32'd6; bVec[2] = 32'd7; bVec[3] = 32'd8;
      applyStimulus(1, 1'b0, 0, 1'b0, 13, 1'b1);
      earlyDone = 0;
      aVec[0] = 32'd6;  aVec[1] = 32'd7;
      bVec[0] = 32'd8;  bVec[1] = 32'd9;
      applyStimulus(0, 1'b0, 2, 1'b0, 8, 1'b1);

      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("err_cleared", 32'(bus.err), 32'd0);
      checkOutput("sb_drained", 32'(expQ.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
